// File: rtl/player_action_decoder_if.sv
// ---------------------------------------------------------------------------
// player_action_decoder_if
// Bundles the button levels and command outputs of the player action decoder.
//   enable                               game active
//   p1_left / p1_right / p1_attack       player 1 debounced button levels
//   p2_left / p2_right / p2_attack       player 2 debounced button levels
//   p1_move_left / p1_move_right         player 1 one-cycle step pulses
//   p1_attack_pulse / p1_attack_ready    player 1 attack command / readiness
//   p2_move_left / p2_move_right         player 2 one-cycle step pulses
//   p2_attack_pulse / p2_attack_ready    player 2 attack command / readiness
// The master modport drives buttons and enable; the slave (decoder) drives
// the commands.
// ---------------------------------------------------------------------------
interface player_action_decoder_if;
    logic enable;
    logic p1_left;
    logic p1_right;
    logic p1_attack;
    logic p2_left;
    logic p2_right;
    logic p2_attack;
    logic p1_move_left;
    logic p1_move_right;
    logic p1_attack_pulse;
    logic p1_attack_ready;
    logic p2_move_left;
    logic p2_move_right;
    logic p2_attack_pulse;
    logic p2_attack_ready;

    modport master (
        output enable,
        output p1_left, p1_right, p1_attack,
        output p2_left, p2_right, p2_attack,
        input  p1_move_left, p1_move_right, p1_attack_pulse, p1_attack_ready,
        input  p2_move_left, p2_move_right, p2_attack_pulse, p2_attack_ready
    );

    modport slave (
        input  enable,
        input  p1_left, p1_right, p1_attack,
        input  p2_left, p2_right, p2_attack,
        output p1_move_left, p1_move_right, p1_attack_pulse, p1_attack_ready,
        output p2_move_left, p2_move_right, p2_attack_pulse, p2_attack_ready
    );
endinterface

// File: rtl/player_action_decoder.sv
// ---------------------------------------------------------------------------
// player_action_decoder
// Turns debounced button levels of two players into one-cycle game commands.
// Move buttons step once on press, then auto-repeat while held; attack
// buttons fire once per press, rate-limited by a cooldown.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      player_action_decoder_if.slave (enable, buttons in, commands out)
// PlayerChannel holds the complete logic of one player; two copies are
// instantiated with no shared state.
// ---------------------------------------------------------------------------
module PlayerChannel #(
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4,
    parameter int ATTACK_COOLDOWN = 10,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_enable,
    input  logic i_left,
    input  logic i_right,
    input  logic i_attack,
    output logic o_moveLeft,
    output logic o_moveRight,
    output logic o_attackPulse,
    output logic o_attackReady
);
    typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_LEFT = 2'd1, DIR_RIGHT = 2'd2} dir_t;
    typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} moveState_t;

    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(ATTACK_COOLDOWN);

    dir_t             w_dir;
    dir_t             r_prevDir;
    moveState_t       r_state;
    logic [CNT_W-1:0] r_moveCnt;
    logic [CNT_W-1:0] r_coolCnt;
    logic [CNT_W-1:0] w_coolNext;
    logic             r_prevAttack;
    logic             w_accept;
    logic             r_moveLeft;
    logic             r_moveRight;
    logic             r_attackPulse;
    logic             r_attackReady;

    // Both buttons held cancel each other out.
    always_comb begin
        w_dir = DIR_NONE;
        if (i_left && !i_right) begin
            w_dir = DIR_LEFT;
        end else if (i_right && !i_left) begin
            w_dir = DIR_RIGHT;
        end
    end

    // Move FSM: a new direction always restarts the sequence; a held
    // direction pulses each time the counter has run down to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_prevDir   <= DIR_NONE;
            r_moveCnt   <= '0;
            r_moveLeft  <= 1'b0;
            r_moveRight <= 1'b0;
        end else begin
            r_prevDir   <= w_dir;
            r_moveLeft  <= 1'b0;
            r_moveRight <= 1'b0;
            if (!i_enable || w_dir == DIR_NONE) begin
                r_state <= IDLE;
            end else if (w_dir != r_prevDir) begin
                r_moveLeft  <= (w_dir == DIR_LEFT);
                r_moveRight <= (w_dir == DIR_RIGHT);
                r_moveCnt   <= DELAY_LOAD;
                r_state     <= DELAY;
            end else begin
                case (r_state)
                    DELAY, REPEAT: begin
                        if (r_moveCnt == '0) begin
                            r_moveLeft  <= (w_dir == DIR_LEFT);
                            r_moveRight <= (w_dir == DIR_RIGHT);
                            r_moveCnt   <= PERIOD_LOAD;
                            r_state     <= REPEAT;
                        end else begin
                            r_moveCnt <= r_moveCnt - CNT_W'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // A press is only accepted on a rising edge with the cooldown expired;
    // edges during cooldown are simply lost.
    assign w_accept = i_enable & i_attack & ~r_prevAttack & (r_coolCnt == '0);

    always_comb begin
        w_coolNext = r_coolCnt;
        if (w_accept) begin
            w_coolNext = COOL_LOAD;
        end else if (r_coolCnt != '0) begin
            w_coolNext = r_coolCnt - CNT_W'(1);
        end
    end

    // Ready is registered from the next cooldown value so it rises in the
    // same cycle the cooldown reaches zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prevAttack  <= 1'b0;
            r_coolCnt     <= '0;
            r_attackPulse <= 1'b0;
            r_attackReady <= 1'b0;
        end else begin
            r_prevAttack  <= i_attack;
            r_coolCnt     <= w_coolNext;
            r_attackPulse <= w_accept;
            r_attackReady <= i_enable & (w_coolNext == '0);
        end
    end

    assign o_moveLeft    = r_moveLeft;
    assign o_moveRight   = r_moveRight;
    assign o_attackPulse = r_attackPulse;
    assign o_attackReady = r_attackReady;
endmodule

module player_action_decoder #(
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4,
    parameter int ATTACK_COOLDOWN = 10,
    parameter int CNT_W           = 24
) (
    input logic                    clk,
    input logic                    reset_n,
    player_action_decoder_if.slave bus
);
    PlayerChannel #(
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
        .ATTACK_COOLDOWN(ATTACK_COOLDOWN), .CNT_W(CNT_W)
    ) u_player1 (
        .clk(clk), .reset_n(reset_n), .i_enable(bus.enable),
        .i_left(bus.p1_left), .i_right(bus.p1_right), .i_attack(bus.p1_attack),
        .o_moveLeft(bus.p1_move_left), .o_moveRight(bus.p1_move_right),
        .o_attackPulse(bus.p1_attack_pulse), .o_attackReady(bus.p1_attack_ready)
    );

    PlayerChannel #(
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
        .ATTACK_COOLDOWN(ATTACK_COOLDOWN), .CNT_W(CNT_W)
    ) u_player2 (
        .clk(clk), .reset_n(reset_n), .i_enable(bus.enable),
        .i_left(bus.p2_left), .i_right(bus.p2_right), .i_attack(bus.p2_attack),
        .o_moveLeft(bus.p2_move_left), .o_moveRight(bus.p2_move_right),
        .o_attackPulse(bus.p2_attack_pulse), .o_attackReady(bus.p2_attack_ready)
    );
endmodule

// File: tb/tb_player_action_decoder.sv
// ---------------------------------------------------------------------------
// tb_player_action_decoder
// Directed scenarios followed by random button activity. Each stimulus cycle
// pushes the expected outputs into a queue; a monitor pops and compares
// after every rising clock edge.
// ---------------------------------------------------------------------------
module tb_player_action_decoder;
    localparam int RD = 8;
    localparam int RP = 4;
    localparam int AC = 10;

    logic clk = 1'b0;
    logic reset_n;
    player_action_decoder_if bus();

    player_action_decoder #(
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ATTACK_COOLDOWN(AC), .CNT_W(24)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int edgeIdx    = 0;
    logic [7:0] sbQueue[$];

    // Reference state: time-stamps of the last press and last accepted attack.
    int  prevDir[2];
    bit  prevAtk[2];
    bit  active[2];
    int  pressEdge[2];
    int  lastAccept[2];

    function automatic logic [7:0] outVec();
        return {bus.p2_attack_ready, bus.p2_attack_pulse, bus.p2_move_right, bus.p2_move_left,
                bus.p1_attack_ready, bus.p1_attack_pulse, bus.p1_move_right, bus.p1_move_left};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s t=%0t got=%b expected=%b", name, $time, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int p = 0; p < 2; p++) begin
            prevDir[p]    = 0;
            prevAtk[p]    = 1'b0;
            active[p]     = 1'b0;
            pressEdge[p]  = 0;
            lastAccept[p] = -100000;
        end
    endtask

    // Expected {ready, attackPulse, moveRight, moveLeft} after this edge.
    task automatic modelPlayer(input int p, input bit en, input bit l, input bit r,
                               input bit a, output logic [3:0] exp);
        int  dir;
        int  d;
        bit  mvL;
        bit  mvR;
        bit  acc;
        bit  rdy;
        dir = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
        mvL = 1'b0;
        mvR = 1'b0;
        if (!en || dir == 0) begin
            active[p] = 1'b0;
        end else if (dir != prevDir[p]) begin
            active[p]    = 1'b1;
            pressEdge[p] = edgeIdx;
            mvL = (dir == 1);
            mvR = (dir == 2);
        end else if (active[p]) begin
            d = edgeIdx - pressEdge[p];
            if (d == RD || (d > RD && (d - RD) % RP == 0)) begin
                mvL = (dir == 1);
                mvR = (dir == 2);
            end
        end
        prevDir[p] = dir;
        acc = en && a && !prevAtk[p] && (edgeIdx - lastAccept[p] >= AC + 1);
        if (acc) lastAccept[p] = edgeIdx;
        rdy = en && (edgeIdx - lastAccept[p] >= AC);
        prevAtk[p] = a;
        exp = {rdy, acc, mvR, mvL};
    endtask

    task automatic applyStimulus(input bit en, input bit l1, input bit r1, input bit a1,
                                 input bit l2, input bit r2, input bit a2);
        logic [3:0] e1;
        logic [3:0] e2;
        @(negedge clk);
        reset_n       = 1'b1;
        bus.enable    = en;
        bus.p1_left   = l1;
        bus.p1_right  = r1;
        bus.p1_attack = a1;
        bus.p2_left   = l2;
        bus.p2_right  = r2;
        bus.p2_attack = a2;
        modelPlayer(0, en, l1, r1, a1, e1);
        modelPlayer(1, en, l2, r2, a2, e2);
        sbQueue.push_back({e2, e1});
        edgeIdx++;
    endtask

    // Monitor: every rising edge produces one output vector to compare.
    always @(posedge clk) begin
        #1;
        if (sbQueue.size() > 0) begin
            checkOutput("outputs", outVec(), sbQueue.pop_front());
        end
    end

    initial begin
        reset_n       = 1'b0;
        bus.enable    = 1'b0;
        bus.p1_left   = 1'b0;
        bus.p1_right  = 1'b0;
        bus.p1_attack = 1'b0;
        bus.p2_left   = 1'b0;
        bus.p2_right  = 1'b0;
        bus.p2_attack = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("resetState", outVec(), 8'h00);

        // Move repeat: left held 30 cycles.
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        repeat (30) applyStimulus(1, 1, 0, 0, 0, 0, 0);
        repeat (5) applyStimulus(1, 0, 0, 0, 0, 0, 0);

        // Direction change, then both buttons together.
        repeat (5) applyStimulus(1, 1, 0, 0, 0, 0, 0);
        repeat (14) applyStimulus(1, 0, 1, 0, 0, 0, 0);
        repeat (6) applyStimulus(1, 1, 1, 0, 0, 0, 0);
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0);

        // Attack cooldown: presses at 0, 5 and 12, then a long hold.
        for (int c = 0; c < 30; c++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, (c == 0 || c == 5 || (c >= 12 && c < 20)));
        end

        // Enable gating: held through enable rise, then re-press, then drop.
        repeat (3) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        repeat (5) applyStimulus(1, 0, 1, 0, 0, 0, 0);
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        repeat (14) applyStimulus(1, 0, 1, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        repeat (4) applyStimulus(1, 0, 1, 0, 0, 0, 0);

        // Player independence.
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        repeat (12) applyStimulus(1, 0, 0, 1, 1, 0, 0);
        repeat (10) applyStimulus(1, 0, 0, 0, 0, 1, 1);
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-repeat and mid-cooldown.
        repeat (12) applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 1);
        repeat (3) applyStimulus(1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n    = 1'b0;
        bus.enable = 1'b0;
        #1;
        checkOutput("asyncReset", outVec(), 8'h00);
        @(posedge clk);
        #1;
        checkOutput("resetHeld", outVec(), 8'h00);
        modelReset();
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        repeat (6) applyStimulus(1, 1, 0, 0, 0, 0, 0);
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        repeat (10) applyStimulus(1, 1, 0, 0, 0, 0, 0);

        // Random activity.
        begin
            bit en;
            bit b[6];
            en = 1'b1;
            for (int i = 0; i < 6; i++) b[i] = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(63) == 0) en = ~en;
                for (int i = 0; i < 6; i++) begin
                    if ($urandom_range((i % 3 == 2) ? 3 : 9) == 0) b[i] = ~b[i];
                end
                applyStimulus(en, b[0], b[1], b[2], b[3], b[4], b[5]);
            end
        end

        @(posedge clk);
        #2;
        if (sbQueue.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain pending=%0d expected=0", sbQueue.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
